step_debouncer: RTL
===================

Name: step_debouncer

Overview:
- Consumes the slow board clock from the clock divider (100 Hz square wave) and a raw active-low push-button (KEY).
- Produces a debounced button level and a single i_clk-cycle step enable for single-stepping the RV32I core on the FPGA board.
- Sits between the divider/board I/O and the core's clock-enable input. A run-mode switch bypasses stepping.

Parameters:
- DEB_SAMPLES, 4, consecutive equal slow-tick samples required to change the debounced level (2..16)
- CNT_W, 8, width of the press counter
- REPEAT_DELAY, 50, slow ticks held before auto-repeat starts (AUTO_REPEAT_EN only)
- REPEAT_PERIOD, 10, slow ticks between auto-repeat pulses (AUTO_REPEAT_EN only)

Ports:
- i_clk  input  1  system clock, 50 MHz
- i_reset  input  1  asynchronous, active-high reset
- i_slow_clk  input  1  divider output; sampled as data, never used as a clock
- i_btn_n  input  1  raw button, active-low, asynchronous
- i_run_mode  input  1  1 = free run, 0 = single-step; asynchronous switch
- o_step_en  output  1  core clock enable
- o_btn_level  output  1  debounced level, 1 = pressed
- o_press_cnt  output  CNT_W  count of accepted presses, wraps

Behaviour:
- Reset values (async, immediate): o_step_en=0, o_btn_level=0, o_press_cnt=0. All sync flops, the sample shift register and the FSM are also reset; the sample shift register resets to all-0 (released).
- Synchronisers:
  - i_btn_n, i_slow_clk and i_run_mode each pass through a 2-FF synchroniser on i_clk.
  - tick = synced slow clock is 1 and its previous registered value is 0 (one i_clk-cycle pulse per slow rising edge).
- Sampling:
  - On tick, shift ~btn_sync into a DEB_SAMPLES-bit register. No shift otherwise.
  - Level update happens in the i_clk cycle after the shift that makes the register all-1 (set o_btn_level=1) or all-0 (clear it). A mixed register holds the level.
- FSM (one i_clk domain), states IDLE, PRESS, HELD:
  - IDLE: on o_btn_level 0->1, go to PRESS.
  - PRESS: lasts exactly one cycle. Asserts the step pulse, increments o_press_cnt (wraps at 2^CNT_W-1 -> 0), then goes to HELD.
  - HELD: stays while o_btn_level=1. On o_btn_level=0, goes to IDLE. No further pulses without the optional feature.
- o_step_en:
  - run_sync=1: o_step_en=1 every cycle. The FSM keeps running and o_press_cnt still counts.
  - run_sync=0: o_step_en is registered and equals 1 only in the cycle after PRESS, so each press produces exactly one high cycle.
  - A run->step transition takes effect 3 cycles after i_run_mode changes: 2 synchroniser stages plus the output register.
- Latency: a clean press is accepted at the DEB_SAMPLES-th slow rising edge after the button is low through the synchroniser. o_step_en then rises at most 4 i_clk cycles after that tick.
- Bounce: any glitch shorter than DEB_SAMPLES consecutive ticks never changes o_btn_level.
- Reset mid-press: the FSM returns to IDLE with level 0. If the button is still held after reset, a new press is accepted after DEB_SAMPLES ticks.
- Slow clock stuck at 0 or 1: no ticks, so outputs hold (no pulse generation).

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - Adds state REPEAT and a tick counter.
  - In HELD, count ticks. At REPEAT_DELAY ticks go to REPEAT and emit one step pulse, incrementing o_press_cnt.
  - In REPEAT, emit one pulse every REPEAT_PERIOD ticks while held.
  - Release from HELD or REPEAT goes to IDLE and clears the counter.
- Undefined: no repeat state or counter logic is present. A held button yields exactly one pulse.

Test Plan:
- Reset asserted mid-simulation with the button held -> outputs 0 immediately; o_btn_level returns to 1 after 4 ticks post-reset and o_press_cnt=1.
- Clean press (i_btn_n=0 for 10 ticks, DEB_SAMPLES=4), run_mode=0 -> exactly one o_step_en cycle within 4 i_clk cycles of the 4th tick; o_press_cnt=1; o_btn_level=1 then 0 four ticks after release.
- Bouncing press (0,1,0,1,0 over 5 ticks, then stable 0) -> o_btn_level stays 0 until 4 stable ticks; exactly one pulse; o_press_cnt=1.
- 256 clean presses with CNT_W=8 -> o_press_cnt wraps to 0; 256 step pulses counted.
- run_mode=1 -> o_step_en=1 every cycle; switch to 0 -> o_step_en low by the 3rd cycle; the next press gives a single pulse.
- AUTO_REPEAT_EN, held 80 ticks (DELAY=50, PERIOD=10) -> pulses at acceptance, +50, +60, +70, +80 ticks; o_press_cnt=5. Without the macro, same stimulus -> o_press_cnt=1.

Source files
------------

// File: rtl/step_debouncer.sv
// Single-step button debouncer: synchronises a raw key and the 100 Hz divider output,
// debounces on slow ticks and emits one i_clk-wide core clock enable per accepted press.
// Optional macro AUTO_REPEAT_EN adds auto-repeat of the step pulse while the key is held.
module step_debouncer #(
   parameter int DEB_SAMPLES = 4,
   parameter int CNT_W       = 8
`ifdef AUTO_REPEAT_EN
   ,
   parameter int REPEAT_DELAY  = 50,
   parameter int REPEAT_PERIOD = 10
`endif
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_slow_clk,
   input  logic             i_btn_n,
   input  logic             i_run_mode,
   output logic             o_step_en,
   output logic             o_btn_level,
   output logic [CNT_W-1:0] o_press_cnt
);

`ifdef AUTO_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   typedef enum logic [1:0] {IDLE, PRESS, HELD, REPEAT} state_t;
`else
   typedef enum logic [1:0] {IDLE, PRESS, HELD} state_t;
`endif

   logic                   btn_meta_q, btn_sync_q;
   logic                   slow_meta_q, slow_sync_q, slow_prev_q;
   logic                   run_meta_q, run_sync_q;
   logic [DEB_SAMPLES-1:0] samples_q, samples_d;
   logic                   level_q, level_d;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       press_cnt_q, press_cnt_d;
   logic                   step_en_q, step_en_d;
   logic                   pulse;
   logic                   tick;
`ifdef AUTO_REPEAT_EN
   logic [REP_W-1:0]       rep_cnt_q, rep_cnt_d;
`endif

   // The slow clock is treated as data: its rising edge becomes a one-cycle tick.
   assign tick = slow_sync_q & ~slow_prev_q;

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         btn_meta_q  <= 1'b1;
         btn_sync_q  <= 1'b1;
         slow_meta_q <= 1'b0;
         slow_sync_q <= 1'b0;
         slow_prev_q <= 1'b0;
         run_meta_q  <= 1'b0;
         run_sync_q  <= 1'b0;
         samples_q   <= '0;
         level_q     <= 1'b0;
         state_q     <= IDLE;
         press_cnt_q <= '0;
         step_en_q   <= 1'b0;
`ifdef AUTO_REPEAT_EN
         rep_cnt_q   <= '0;
`endif
      end else begin
         btn_meta_q  <= i_btn_n;
         btn_sync_q  <= btn_meta_q;
         slow_meta_q <= i_slow_clk;
         slow_sync_q <= slow_meta_q;
         slow_prev_q <= slow_sync_q;
         run_meta_q  <= i_run_mode;
         run_sync_q  <= run_meta_q;
         samples_q   <= samples_d;
         level_q     <= level_d;
         state_q     <= state_d;
         press_cnt_q <= press_cnt_d;
         step_en_q   <= step_en_d;
`ifdef AUTO_REPEAT_EN
         rep_cnt_q   <= rep_cnt_d;
`endif
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      samples_d = samples_q;
      level_d   = level_q;
      if (tick) begin
         samples_d = {samples_q[DEB_SAMPLES-2:0], ~btn_sync_q};
      end
      // A mixed sample window holds the previous level.
      if (&samples_q) begin
         level_d = 1'b1;
      end else if (~|samples_q) begin
         level_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      pulse   = 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_cnt_d = rep_cnt_q;
`endif
      case (state_q)
         IDLE: begin
`ifdef AUTO_REPEAT_EN
            rep_cnt_d = '0;
`endif
            if (level_q) begin
               state_d = PRESS;
            end
         end
         PRESS: begin
            pulse   = 1'b1;
            state_d = HELD;
         end
         HELD: begin
            if (!level_q) begin
               state_d = IDLE;
`ifdef AUTO_REPEAT_EN
               rep_cnt_d = '0;
            end else if (tick) begin
               if (rep_cnt_q == REP_W'(REPEAT_DELAY - 1)) begin
                  state_d   = REPEAT;
                  pulse     = 1'b1;
                  rep_cnt_d = '0;
               end else begin
                  rep_cnt_d = rep_cnt_q + REP_W'(1);
               end
`endif
            end
         end
`ifdef AUTO_REPEAT_EN
         REPEAT: begin
            if (!level_q) begin
               state_d   = IDLE;
               rep_cnt_d = '0;
            end else if (tick) begin
               if (rep_cnt_q == REP_W'(REPEAT_PERIOD - 1)) begin
                  pulse     = 1'b1;
                  rep_cnt_d = '0;
               end else begin
                  rep_cnt_d = rep_cnt_q + REP_W'(1);
               end
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Run mode forces the enable high but the press FSM and counter keep working.
   assign press_cnt_d = pulse ? press_cnt_q + CNT_W'(1) : press_cnt_q;
   assign step_en_d   = run_sync_q | pulse;

   assign o_step_en   = step_en_q;
   assign o_btn_level = level_q;
   assign o_press_cnt = press_cnt_q;

endmodule
